spi_resp_slave: RTL and testbench
=================================

# spi_resp_slave

System-clocked SPI slave that handles both directions of a 12-bit SPI frame. It deserialises MOSI into `rx_data` and serialises a preloaded word onto MISO, with both words sent LSB-first. `sclk`, `cs` and `mosi` are asynchronous to `clk` and are synchronised and edge-detected internally. The block sits on the device side of the link, opposite `spi_master`, and adds the MISO return path that the existing point-to-point link does not have.

## Interface
- `WIDTH`, 12: frame length in bits.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `cs` and `mosi`. Minimum 2.
- `clk` input 1: system clock. All state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset. Released synchronously to `clk`.
- `sclk` input 1: SPI clock from the master, mode 0 (idles low).
- `cs` input 1: chip select, active-low.
- `mosi` input 1: serial data from the master.
- `miso` output 1: serial data to the master.
- `tx_data` input WIDTH: word to return in the next frame.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: the transmit holding register is empty.
- `rx_data` output WIDTH: last completely received word.
- `rx_valid` output 1: one-`clk` pulse when `rx_data` updates.
- `frame_err` output 1: one-`clk` pulse when `cs` rises before WIDTH bits are received.
- `underrun` output 1: one-`clk` pulse when a frame starts with no transmit word loaded.

## Operation
- Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `underrun`=0.
- Reset also clears the FSM to IDLE, `bit_cnt` to 0, both shift registers to 0 and the synchroniser flops to idle levels (`sclk`=0, `cs`=1, `mosi`=0).
- Synchronised signals are `sclk_s`, `cs_s` and `mosi_s`.
- Edge flags:
  - `sclk_rise`/`sclk_fall` come from `sclk_s` compared with its previous registered value.
  - `cs_fall`/`cs_rise` come from `cs_s` in the same way.
- Transmit holding register (one entry):
  - A load happens when `tx_valid` && `tx_ready`.
  - `tx_ready` deasserts on the cycle after the load.
  - The register is consumed at frame start, and `tx_ready` reasserts on the next cycle.
  - A load during a frame is allowed; that word goes out in the following frame.
  - If a load and a consume occur in the same cycle, the old word is consumed and the new word is held, so `tx_ready` stays 0.
- FSM states: IDLE, SHIFT, WAIT_CS.
- IDLE: `miso`=0. On `cs_fall`:
  - If the holding register is full, `tx_shift` ← holding register. Otherwise `tx_shift` ← 0 and `underrun` pulses.
  - `miso` ← bit 0 of the loaded value.
  - `bit_cnt` ← 0.
  - Go to SHIFT.
- SHIFT:
  - On `sclk_rise`: `rx_shift` ← {`mosi_s`, `rx_shift`[WIDTH-1:1]} and `bit_cnt` ← `bit_cnt`+1.
  - On `sclk_fall` with 0 < `bit_cnt` < WIDTH: `miso` ← `tx_shift`[`bit_cnt`].
  - When the rise takes `bit_cnt` to WIDTH: on the next cycle `rx_data` ← `rx_shift` (already shifted) and `rx_valid` pulses. Go to WAIT_CS.
  - On `cs_rise` with `bit_cnt` < WIDTH: `frame_err` pulses, the partial word is discarded (`rx_data` is unchanged), `miso` ← 0, go to IDLE.
- WAIT_CS:
  - `miso` holds the last bit.
  - Extra `sclk` edges are ignored, because the master may issue an extra edge before raising `cs`.
  - On `cs_rise`: `miso` ← 0 and go to IDLE.
- `bit_cnt` is $clog2(WIDTH+1) bits wide and never wraps. It saturates at WIDTH.
- If `cs_fall` and an `sclk` edge are flagged in the same cycle, `cs` takes priority. The `sclk` edge is ignored.

## Timing
- Input-to-flag latency: SYNC_STAGES+1 `clk` cycles from a pin transition.
- `rx_valid` is high SYNC_STAGES+2 `clk` cycles after the WIDTH-th `sclk` rising edge at the pin.
- `miso` updates SYNC_STAGES+1 cycles after the `sclk` falling edge or `cs` falling edge at the pin.
- Required master timing:
  - `sclk` high and low phases are each at least SYNC_STAGES+3 `clk` cycles.
  - The first `sclk` rise is at least SYNC_STAGES+3 cycles after `cs` falls.
  - The existing master (11-`clk` half-period) meets this.
- Reset asserted mid-frame returns every output to its reset value immediately. No `rx_valid` or `frame_err` is produced for that frame.
- No combinational path from any input to any output.

## Test plan
- Reset, then send MOSI 12'hA5C LSB-first in mode 0 with an 11-`clk` half-period and the holding register empty → `underrun`=1 pulse at frame start, MISO returns 12'h000, one `rx_valid` pulse, `rx_data`=12'hA5C.
- Load `tx_data`=12'h3C7, then send MOSI 12'h0F1 → bits sampled on MISO at `sclk` rises are, LSB-first, 1,1,1,0,0,0,1,1,1,1,0,0. `rx_data`=12'h0F1. `tx_ready` goes 0 after the load and back to 1 at frame start.
- Load 12'h111, then load 12'h222 during the frame → frame 1 returns 12'h111 and frame 2 returns 12'h222. `tx_ready` stays 0 while 12'h222 is held.
- Raise `cs` after 5 bits of 12'hFFF → `frame_err` pulses once, no `rx_valid`, `rx_data` keeps its previous value, FSM back in IDLE, and the next full frame 12'h123 is received correctly.
- Master issues a 13th `sclk` edge before raising `cs` → exactly one `rx_valid`, `rx_data` unchanged by the extra edge, no `frame_err`.
- Assert `rst` (low) after bit 7 of a frame → all outputs at reset values within the same cycle. After release, frame 12'hFFE is received as 12'hFFE.

Source files
------------

// File: rtl/spi_resp_slave.sv
// spi_resp_slave: system-clocked SPI mode-0 slave with a 12-bit full-duplex frame.
// MOSI is deserialised into rx_data and a preloaded word is shifted out on MISO,
// both LSB-first. sclk/cs/mosi are asynchronous and are synchronised internally.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | cs high, miso driven 0, waiting for cs to fall
// SHIFT   | frame in progress, sampling mosi on sclk rise, driving miso on fall
// WAIT_CS | all bits received, extra sclk edges ignored until cs rises
module spi_resp_slave #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             underrun
);

  localparam int             CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // Reset synchroniser: assertion is immediate, release follows clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // Reset synchroniser register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  // Input synchroniser chains and previous-value registers for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Next values of the synchroniser chains.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  // Synchroniser registers reset to idle bus levels so no false edge fires.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Frame state and datapath registers.
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0]  tx_sel;
  logic              hold_full_q, hold_full_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              underrun_q, underrun_d;
  logic              consume, load;

  // Frame FSM: next state, shift registers, miso and status pulses.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;
    consume     = 1'b0;
    tx_sel      = tx_shift_q >> bit_cnt_q;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        // cs_fall wins over any coincident sclk edge simply by not looking at sclk here.
        if (cs_fall) begin
          consume    = hold_full_q;
          tx_shift_d = hold_full_q ? hold_q : '0;
          underrun_d = ~hold_full_q;
          miso_d     = hold_full_q & hold_q[0];
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == CNT_MAX) begin
          // Last bit was shifted in on the previous cycle; publish the word.
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          if (cs_rise) begin
            miso_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT_CS;
          end
        end else if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          miso_d = tx_sel[0];
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // One-entry transmit holding register; a consume frees it, a load fills it.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = tx_valid & ~hold_full_q;
    if (consume) hold_full_d = 1'b0;
    if (load) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = ~hold_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_resp_slave.sv
// Directed bench for spi_resp_slave: a behavioural SPI master with an
// 11-clk half-period drives frames; expected words are hand-computed.
module tb_spi_resp_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic [11:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  int ur_cnt = 0;

  spi_resp_slave #(.WIDTH(12), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // Count pulse cycles on the status outputs, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1)  rv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (underrun === 1'b1)  ur_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input logic [11:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master: mosi changes with sclk fall, miso sampled just before each rise.
  task automatic send_frame(input logic [11:0] word, input int nbits, input bit extra,
                            input bit mid_load, input logic [11:0] mid_word,
                            output logic [11:0] miso_word, output logic rdy_mid);
    miso_word = '0;
    rdy_mid   = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[i];
      if (mid_load && i == 4) begin
        wait_clk(1);
        tx_data  = mid_word;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        wait_clk(9);
      end else begin
        wait_clk(11);
      end
      if (i == 0) rdy_mid = tx_ready;
      miso_word[i] = miso;
      sclk = 1'b1;
      wait_clk(11);
      sclk = 1'b0;
    end
    if (extra) begin
      mosi = 1'b1;
      wait_clk(11);
      sclk = 1'b1;
      wait_clk(11);
      sclk = 1'b0;
    end
    wait_clk(11);
    cs   = 1'b1;
    mosi = 1'b0;
    wait_clk(11);
  endtask

  initial begin
    logic [11:0] mw;
    logic        rdy;
    int          b_rv, b_fe, b_ur;

    rst      = 1'b0;
    cs       = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    wait_clk(3);
    check("rst_miso", {31'b0, miso}, 32'd0);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_rx_data", {20'b0, rx_data}, 32'h0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_underrun", {31'b0, underrun}, 32'd0);
    rst = 1'b1;
    wait_clk(5);

    // Frame with empty holding register: underrun, zero return word.
    b_rv = rv_cnt; b_fe = fe_cnt; b_ur = ur_cnt;
    send_frame(12'hA5C, 12, 1'b0, 1'b0, 12'h000, mw, rdy);
    check("f1_underrun", ur_cnt - b_ur, 32'd1);
    check("f1_miso", {20'b0, mw}, 32'h000);
    check("f1_rx_valid", rv_cnt - b_rv, 32'd1);
    check("f1_rx_data", {20'b0, rx_data}, 32'hA5C);
    check("f1_frame_err", fe_cnt - b_fe, 32'd0);

    // Preloaded word 3C7 goes out while 0F1 comes in.
    load_word(12'h3C7);
    check("f2_ready_after_load", {31'b0, tx_ready}, 32'd0);
    b_rv = rv_cnt; b_ur = ur_cnt;
    send_frame(12'h0F1, 12, 1'b0, 1'b0, 12'h000, mw, rdy);
    check("f2_ready_at_start", {31'b0, rdy}, 32'd1);
    check("f2_miso", {20'b0, mw}, 32'h3C7);
    check("f2_rx_data", {20'b0, rx_data}, 32'h0F1);
    check("f2_rx_valid", rv_cnt - b_rv, 32'd1);
    check("f2_underrun", ur_cnt - b_ur, 32'd0);

    // Load during a frame is held for the next one.
    load_word(12'h111);
    b_ur = ur_cnt;
    send_frame(12'h5A5, 12, 1'b0, 1'b1, 12'h222, mw, rdy);
    check("f3_miso", {20'b0, mw}, 32'h111);
    check("f3_rx_data", {20'b0, rx_data}, 32'h5A5);
    check("f3_ready_held", {31'b0, tx_ready}, 32'd0);
    send_frame(12'h36C, 12, 1'b0, 1'b0, 12'h000, mw, rdy);
    check("f4_miso", {20'b0, mw}, 32'h222);
    check("f4_rx_data", {20'b0, rx_data}, 32'h36C);
    check("f4_ready_after", {31'b0, tx_ready}, 32'd1);
    check("f34_underrun", ur_cnt - b_ur, 32'd0);

    // Aborted frame after 5 bits of FFF.
    b_rv = rv_cnt; b_fe = fe_cnt;
    send_frame(12'hFFF, 5, 1'b0, 1'b0, 12'h000, mw, rdy);
    check("abort_frame_err", fe_cnt - b_fe, 32'd1);
    check("abort_rx_valid", rv_cnt - b_rv, 32'd0);
    check("abort_rx_data", {20'b0, rx_data}, 32'h36C);
    check("abort_miso_idle", {31'b0, miso}, 32'd0);
    b_rv = rv_cnt; b_fe = fe_cnt;
    send_frame(12'h123, 12, 1'b0, 1'b0, 12'h000, mw, rdy);
    check("after_abort_rx_data", {20'b0, rx_data}, 32'h123);
    check("after_abort_rx_valid", rv_cnt - b_rv, 32'd1);
    check("after_abort_frame_err", fe_cnt - b_fe, 32'd0);

    // Extra 13th sclk edge before cs rises.
    b_rv = rv_cnt; b_fe = fe_cnt;
    send_frame(12'h9C3, 12, 1'b1, 1'b0, 12'h000, mw, rdy);
    check("extra_rx_valid", rv_cnt - b_rv, 32'd1);
    check("extra_rx_data", {20'b0, rx_data}, 32'h9C3);
    check("extra_frame_err", fe_cnt - b_fe, 32'd0);

    // Reset asserted after bit 7 of a frame returning FFF.
    load_word(12'hFFF);
    b_rv = rv_cnt; b_fe = fe_cnt;
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      wait_clk(11);
      sclk = 1'b1;
      wait_clk(11);
      sclk = 1'b0;
    end
    load_word(12'h555);
    wait_clk(3);
    check("pre_rst_miso", {31'b0, miso}, 32'd1);
    check("pre_rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_miso", {31'b0, miso}, 32'd0);
    check("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("midrst_rx_data", {20'b0, rx_data}, 32'h0);
    check("midrst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("midrst_frame_err", {31'b0, frame_err}, 32'd0);
    check("midrst_underrun", {31'b0, underrun}, 32'd0);
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(5);
    check("rstframe_rx_valid", rv_cnt - b_rv, 32'd0);
    check("rstframe_frame_err", fe_cnt - b_fe, 32'd0);

    b_rv = rv_cnt; b_ur = ur_cnt;
    send_frame(12'hFFE, 12, 1'b0, 1'b0, 12'h000, mw, rdy);
    check("post_rst_rx_data", {20'b0, rx_data}, 32'hFFE);
    check("post_rst_rx_valid", rv_cnt - b_rv, 32'd1);
    check("post_rst_underrun", ur_cnt - b_ur, 32'd1);
    check("post_rst_miso", {20'b0, mw}, 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
